// File: rtl/f6_fc.sv
// f6_fc: fully-connected F6 layer engine. One MAC per cycle: streams the
// N_IN F5 activations against the F6 weight ROM for each of N_OUT neurons,
// adds the neuron bias, saturates to Q8.8, applies ReLU and writes the result.
module f6_fc #(
    parameter int N_IN   = 120,
    parameter int N_OUT  = 84,
    parameter int RD_LAT = 3,
    parameter int ACC_W  = 40
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [4:0]         f5_raddr,
    output logic [3:0]         f5_sel,
    input  logic signed [15:0] f5_rdata,
    output logic [13:0]        w_addr,
    input  logic signed [15:0] w_data,
    output logic [6:0]         b_addr,
    input  logic signed [15:0] b_data,
    output logic [6:0]         f6_waddr,
    output logic [15:0]        f6_wdata,
    output logic               f6_wr_en,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    localparam int CNT_W = $clog2(RD_LAT + 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    logic [1:0]              state;
    logic [6:0]              i_cnt;
    logic [6:0]              j_cnt;
    logic [13:0]             w_cnt;
    logic [CNT_W-1:0]        drain_cnt;
    logic [RD_LAT-1:0]       vld_p;
    logic signed [ACC_W-1:0] acc;
    logic signed [15:0]      bias;
    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] pre_sat;

    // Clamp a wide signed value to the Q8.8 range.
    function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX)      return 16'sh7FFF;
        else if (v < SAT_MIN) return 16'sh8000;
        else                  return v[15:0];
    endfunction

    // Negative results become zero.
    function automatic logic [15:0] relu(input logic signed [15:0] v);
        return v[15] ? 16'h0000 : v;
    endfunction

    assign prod    = f5_rdata * w_data;
    assign pre_sat = (acc >>> 8) + ACC_W'(bias);

    // Sequencer, read-tag pipeline, accumulator and bias capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            i_cnt     <= '0;
            j_cnt     <= '0;
            w_cnt     <= '0;
            drain_cnt <= '0;
            vld_p     <= '0;
            acc       <= '0;
            bias      <= '0;
            done      <= 1'b0;
        end else begin
            done  <= 1'b0;
            // Tags shadow the issued reads; the oldest one marks returning data.
            vld_p <= (vld_p << 1) | RD_LAT'(state == S_ISSUE);
            if (vld_p[RD_LAT-1])
                acc <= acc + {{(ACC_W-32){prod[31]}}, prod};

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_ISSUE;
                        i_cnt <= '0;
                        j_cnt <= '0;
                        w_cnt <= '0;
                        acc   <= '0;
                    end
                end
                S_ISSUE: begin
                    // w_cnt keeps running so it lands on the next neuron's base.
                    i_cnt <= i_cnt + 7'd1;
                    w_cnt <= w_cnt + 14'd1;
                    if (i_cnt == 7'(RD_LAT))
                        bias <= b_data;
                    if (i_cnt == 7'(N_IN - 1)) begin
                        state     <= S_DRAIN;
                        drain_cnt <= '0;
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= drain_cnt + CNT_W'(1);
                    if (drain_cnt == CNT_W'(RD_LAT - 1))
                        state <= S_WRITE;
                end
                default: begin
                    acc   <= '0;
                    i_cnt <= '0;
                    if (j_cnt == 7'(N_OUT - 1)) begin
                        state <= S_IDLE;
                        j_cnt <= '0;
                        w_cnt <= '0;
                        done  <= 1'b1;
                    end else begin
                        state <= S_ISSUE;
                        j_cnt <= j_cnt + 7'd1;
                    end
                end
            endcase
        end
    end

    // Read addresses come straight from the counter registers.
    always_comb begin
        f5_raddr = {2'b00, i_cnt[6:4]};
        f5_sel   = i_cnt[3:0];
        w_addr   = w_cnt;
        b_addr   = j_cnt;
        busy     = (state != S_IDLE);
        f6_wr_en = (state == S_WRITE);
        f6_waddr = (state == S_WRITE) ? j_cnt : 7'd0;
        f6_wdata = (state == S_WRITE) ? relu(sat16(pre_sat)) : 16'h0000;
    end

endmodule

// File: tb/tb_f6_fc.sv
// tb_f6_fc: self-checking bench for f6_fc with fixed-latency memory models
// and a whole-layer arithmetic reference.
module tb_f6_fc;

    localparam int N_IN   = 120;
    localparam int N_OUT  = 84;
    localparam int RD_LAT = 3;
    localparam int ACC_W  = 40;
    localparam int NEURON_CYC = N_IN + RD_LAT + 1;
    localparam int LAST_WR    = 1 + (N_OUT - 1) * NEURON_CYC + NEURON_CYC - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [4:0]         f5_raddr;
    logic [3:0]         f5_sel;
    logic signed [15:0] f5_rdata;
    logic [13:0]        w_addr;
    logic signed [15:0] w_data;
    logic [6:0]         b_addr;
    logic signed [15:0] b_data;
    logic [6:0]         f6_waddr;
    logic [15:0]        f6_wdata;
    logic               f6_wr_en;
    logic               busy;
    logic               done;

    int tests = 0;
    int fails = 0;

    logic signed [15:0] f5_mem [N_IN];
    logic signed [15:0] w_mem  [N_IN*N_OUT];
    logic signed [15:0] b_mem  [N_OUT];
    logic [15:0]        exp_out[N_OUT];

    logic [8:0]  f5_d1, f5_d2, f5_d3;
    logic [13:0] w_d1, w_d2, w_d3;
    logic [6:0]  b_d1, b_d2, b_d3;

    f6_fc #(.N_IN(N_IN), .N_OUT(N_OUT), .RD_LAT(RD_LAT), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .f5_raddr(f5_raddr), .f5_sel(f5_sel), .f5_rdata(f5_rdata),
        .w_addr(w_addr), .w_data(w_data),
        .b_addr(b_addr), .b_data(b_data),
        .f6_waddr(f6_waddr), .f6_wdata(f6_wdata), .f6_wr_en(f6_wr_en),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Memories answer exactly RD_LAT cycles after the address is presented.
    always @(posedge clk) begin
        f5_d1 <= {f5_raddr, f5_sel};
        f5_d2 <= f5_d1;
        f5_d3 <= f5_d2;
        w_d1  <= w_addr;
        w_d2  <= w_d1;
        w_d3  <= w_d2;
        b_d1  <= b_addr;
        b_d2  <= b_d1;
        b_d3  <= b_d2;
    end

    always_comb begin
        f5_rdata = '0;
        w_data   = '0;
        b_data   = '0;
        if (int'(f5_d3) < N_IN)       f5_rdata = f5_mem[int'(f5_d3)];
        if (int'(w_d3) < N_IN*N_OUT)  w_data   = w_mem[int'(w_d3)];
        if (int'(b_d3) < N_OUT)       b_data   = b_mem[int'(b_d3)];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_idle(input string tag);
        check(tag, {f5_raddr, f5_sel, w_addr, b_addr, f6_waddr, f6_wdata, f6_wr_en, busy, done}, 64'd0);
    endtask

    // Reference: dot product, Q8.8 rescale by floor division, bias, then clamp to [0, 0x7FFF].
    function automatic void build_model();
        for (int j = 0; j < N_OUT; j++) begin
            longint s;
            s = 0;
            for (int i = 0; i < N_IN; i++)
                s += longint'(f5_mem[i]) * longint'(w_mem[j*N_IN + i]);
            s = (s >>> 8) + longint'(b_mem[j]);
            if (s > 32767) s = 32767;
            if (s < 0)     s = 0;
            exp_out[j] = 16'(s);
        end
    endfunction

    function automatic void fill(input int kind);
        for (int i = 0; i < N_IN; i++) begin
            case (kind)
                0: f5_mem[i] = 16'sh0100;
                1: f5_mem[i] = 16'(i);
                2: f5_mem[i] = 16'($urandom);
                default: f5_mem[i] = 16'sh7FFF;
            endcase
        end
        for (int j = 0; j < N_OUT; j++) begin
            case (kind)
                0: b_mem[j] = 16'sh0000;
                1: b_mem[j] = 16'sh0010;
                2: b_mem[j] = 16'($urandom);
                default: b_mem[j] = 16'sh0000;
            endcase
            for (int i = 0; i < N_IN; i++) begin
                case (kind)
                    0: w_mem[j*N_IN + i] = 16'sh0100;
                    1: w_mem[j*N_IN + i] = (i == j) ? 16'sh0100 : 16'sh0000;
                    2: w_mem[j*N_IN + i] = 16'(int'($urandom_range(0, 1023)) - 512);
                    3: w_mem[j*N_IN + i] = 16'sh7FFF;
                    default: w_mem[j*N_IN + i] = 16'sh8001;
                endcase
            end
        end
        build_model();
    endfunction

    // Starts a layer (start high in cycle 0) and checks every cycle up to done.
    task automatic run_layer(input string name, input int stray_cyc);
        int nw;
        bit fin;
        nw  = 0;
        fin = 0;
        start = 1'b1;
        step();
        for (int c = 1; c <= LAST_WR + 200 && !fin; c++) begin
            int n, k;
            start = (c == stray_cyc);
            n = (c - 1) / NEURON_CYC;
            k = (c - 1) % NEURON_CYC;
            if (c <= LAST_WR) begin
                check({name, "_busy"}, {63'd0, busy}, 64'd1);
                check({name, "_done_low"}, {63'd0, done}, 64'd0);
                if (k < N_IN)
                    check({name, "_issue_addr"}, {f5_raddr, f5_sel, w_addr, b_addr},
                          {5'(k / 16), 4'(k % 16), 14'(n*N_IN + k), 7'(n)});
                if (k == NEURON_CYC - 1) begin
                    check({name, "_wr"}, {f6_wr_en, f6_waddr, f6_wdata}, {1'b1, 7'(n), exp_out[n]});
                end else begin
                    check({name, "_no_wr"}, {f6_wr_en, f6_waddr, f6_wdata}, 64'd0);
                end
                if (f6_wr_en) nw++;
            end else begin
                check({name, "_done"}, {done, busy, f6_wr_en}, {1'b1, 1'b0, 1'b0});
                check({name, "_wr_count"}, 64'(nw), 64'(N_OUT));
                fin = 1;
            end
            if (!fin) step();
        end
        start = 1'b0;
        if (!fin) check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        // Reset held two cycles with start asserted.
        rst   = 1'b1;
        start = 1'b1;
        step();
        check_idle("reset_c1");
        step();
        check_idle("reset_c2");
        rst   = 1'b0;
        start = 1'b0;
        step();
        check_idle("idle_after_reset");
        step();
        check_idle("idle_no_issue");

        fill(0);
        run_layer("ones_stray_start", 500);
        fill(1);
        run_layer("mapping", -1);
        fill(2);
        run_layer("random", -1);
        fill(3);
        run_layer("sat_pos", -1);
        fill(4);
        run_layer("sat_neg", -1);

        // Reset in the middle of a neuron, then a clean restart.
        fill(0);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 300; c++) step();
        check("mid_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        step();
        check_idle("mid_reset");
        rst = 1'b0;
        step();
        check_idle("mid_reset_hold");
        run_layer("ones_restart", -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
